serial_sub: RTL and testbench

Bit-serial N-bit subtractor controller built around a single 1-bit full subtractor cell.

- Captures two WIDTH-bit operands and an initial borrow on a start handshake.
- Feeds one bit pair per clock into the cell, LSB first, holding the borrow in a flop between bits.
- Presents the WIDTH-bit difference and final borrow with a one-cycle done pulse.
- Sits between the lab operand registers and the result display/compare logic, replacing a WIDTH-wide ripple subtractor with one cell plus sequencing.

---
 rtl/serial_sub_pkg.sv | 20 ++
 rtl/serial_sub_if.sv | 36 +++
 rtl/serial_sub_full_sub.sv | 22 ++
 rtl/serial_sub.sv | 115 +++++++++++
 tb/tb_serial_sub.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// ============================================================================
// Module   : serial_sub_pkg
// Brief    : Shared state encoding and default width for the serial subtractor
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_sub_pkg;

  localparam int C_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_sub_if.sv
// ============================================================================
// Module   : serial_sub_if
// Brief    : Start/result handshake bundle between operand regs and subtractor
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_sub_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  ready, busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output ready, busy, done, diff, bout
  );

endinterface

`default_nettype wire

// File: rtl/serial_sub_full_sub.sv
// ============================================================================
// Module   : full_sub
// Brief    : 1-bit full subtractor cell: sub = A - B - Bin, Bout = borrow
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_sub (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic sub,
  output logic Bout
);

  assign sub  = A ^ B ^ Bin;
  // Borrow when B exceeds A, or when A==B and a borrow is already pending.
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

`default_nettype wire

// File: rtl/serial_sub.sv
// ============================================================================
// Module   : serial_sub
// Brief    : Bit-serial WIDTH-bit subtractor sequencing one full_sub cell
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_sub_if.slave    bus
);

  localparam int                CNT_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_res_sh;
  logic               r_brw;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;

  logic               w_sub;
  logic               w_bout;
  logic [WIDTH-1:0]   w_res_next;

  full_sub u_cell (
    .A    (r_a_sh[0]),
    .B    (r_b_sh[0]),
    .Bin  (r_brw),
    .sub  (w_sub),
    .Bout (w_bout)
  );

  // New bit enters at the MSB so that after WIDTH shifts the LSB lands at bit 0.
  always_comb begin
    w_res_next            = r_res_sh >> 1;
    w_res_next[WIDTH-1]   = w_sub;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_brw    <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_brw    <= bus.bin;
            r_res_sh <= '0;
            r_cnt    <= '0;
            r_state  <= ST_SHIFT;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        ST_SHIFT: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_brw    <= w_bout;
          r_res_sh <= w_res_next;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == C_LAST) begin
            r_diff  <= w_res_next;
            r_bout  <= w_bout;
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.diff  = r_diff;
  assign bus.bout  = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub.sv
// ============================================================================
// Module   : tb_serial_sub
// Brief    : Randomised self-checking bench for serial_sub (WIDTH=8 and WIDTH=1)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_sub;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  serial_sub_if #(.WIDTH(8)) bus8 ();
  serial_sub_if #(.WIDTH(1)) bus1 ();

  serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_sub #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer subtraction, reduced modulo 2^w; borrow iff negative.
  function automatic void model(input int w, input longint a, input longint b,
                                input longint bin, output longint d, output logic bo);
    longint r;
    r  = a - b - bin;
    bo = (r < 0);
    d  = r & ((64'sd1 <<< w) - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation on the 8-bit DUT; lat counts edges from accept to done (-1 = timeout).
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     output logic [7:0] d, output logic bo, output int lat,
                     output logic done_after, output logic rdy_after);
    bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus8.done) begin lat = i; break; end
    end
    d  = bus8.diff;
    bo = bus8.bout;
    tick();
    done_after = bus8.done;
    rdy_after  = bus8.ready;
  endtask

  task automatic op1(input logic a, input logic b, input logic bin,
                     output logic d, output logic bo, output int lat);
    bus1.a = a; bus1.b = b; bus1.bin = bin; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    bus1.a = ~a; bus1.b = ~b; bus1.bin = ~bin;
    lat = -1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (bus1.done) begin lat = i; break; end
    end
    d  = bus1.diff;
    bo = bus1.bout;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({bus8.ready, bus8.busy, bus8.done, bus8.diff, bus8.bout} !== {3'b100, 8'h00, 1'b0}) begin
      n_errors++;
      $display("FAIL reset8: rdy/busy/done=%b%b%b diff=%h bout=%b, want 100 00 0",
               bus8.ready, bus8.busy, bus8.done, bus8.diff, bus8.bout);
    end
    n_checks++;
    if ({bus1.ready, bus1.busy, bus1.done, bus1.diff, bus1.bout} !== 5'b10000) begin
      n_errors++;
      $display("FAIL reset1: rdy/busy/done/diff/bout=%b%b%b%b%b, want 10000",
               bus1.ready, bus1.busy, bus1.done, bus1.diff, bus1.bout);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [7:0] va [4] = '{8'h5A, 8'h00, 8'h10, 8'h0F};
    logic [7:0] vb [4] = '{8'h3C, 8'h01, 8'h0F, 8'h0F};
    logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] ed [4] = '{8'h1E, 8'hFF, 8'h00, 8'hFF};
    logic       eb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] d;
    logic       bo, da, ra;
    int         lat;
    for (int i = 0; i < 4; i++) begin
      op8(va[i], vb[i], vc[i], d, bo, lat, da, ra);
      n_checks++;
      if (d !== ed[i] || bo !== eb[i]) begin
        n_errors++;
        $display("FAIL directed[%0d]: diff=%h bout=%b, want %h %b", i, d, bo, ed[i], eb[i]);
      end
      // done is high in cycle WIDTH+1 counting the accept cycle, i.e. WIDTH edges after accept.
      n_checks++;
      if (lat != 8) begin
        n_errors++;
        $display("FAIL directed_latency[%0d]: got %0d edges, want 8", i, lat);
      end
      n_checks++;
      if (da !== 1'b0 || ra !== 1'b1) begin
        n_errors++;
        $display("FAIL directed_pulse[%0d]: done/ready after=%b%b, want 01", i, da, ra);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, d;
    logic       bin, bo, da, ra, ebo;
    longint     ed;
    int         lat;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      if (i == 0) begin a = 8'hFF; b = 8'hFF; bin = 1'b1; end
      if (i == 1) begin a = 8'hFF; b = 8'h00; bin = 1'b0; end
      op8(a, b, bin, d, bo, lat, da, ra);
      model(8, longint'(a), longint'(b), longint'(bin), ed, ebo);
      n_checks++;
      if (d !== ed[7:0] || bo !== ebo || lat != 8) begin
        n_errors++;
        $display("FAIL random[%0d]: %h-%h-%b diff=%h bout=%b lat=%0d, want %h %b 8",
                 i, a, b, bin, d, bo, lat, ed[7:0], ebo);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a1, b1, a2, b2;
    logic       c1, c2, ebo, rdy_bad;
    longint     ed;
    int         lat1, gap;
    a1 = 8'($urandom); b1 = 8'($urandom); c1 = 1'($urandom);
    a2 = 8'($urandom); b2 = 8'($urandom); c2 = 1'($urandom);
    rdy_bad = 1'b0;
    bus8.a = a1; bus8.b = b1; bus8.bin = c1; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    lat1 = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) begin
        bus8.a = a2; bus8.b = b2; bus8.bin = c2; bus8.start = 1'b1;
      end
      if (bus8.ready) rdy_bad = 1'b1;
      if (bus8.done) begin lat1 = i; break; end
    end
    model(8, longint'(a1), longint'(b1), longint'(c1), ed, ebo);
    n_checks++;
    if (bus8.diff !== ed[7:0] || bus8.bout !== ebo || lat1 != 8) begin
      n_errors++;
      $display("FAIL b2b_first: diff=%h bout=%b lat=%0d, want %h %b 8",
               bus8.diff, bus8.bout, lat1, ed[7:0], ebo);
    end
    n_checks++;
    if (rdy_bad) begin
      n_errors++;
      $display("FAIL b2b_ready_low: ready=1 seen during SHIFT/DONE, want 0");
    end
    // Next accept is the edge after the following IDLE cycle: WIDTH+2 edges between done pulses.
    gap = -1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (bus8.done) begin gap = i; break; end
    end
    bus8.start = 1'b0;
    model(8, longint'(a2), longint'(b2), longint'(c2), ed, ebo);
    n_checks++;
    if (bus8.diff !== ed[7:0] || bus8.bout !== ebo || gap != 10) begin
      n_errors++;
      $display("FAIL b2b_second: diff=%h bout=%b gap=%0d, want %h %b 10",
               bus8.diff, bus8.bout, gap, ed[7:0], ebo);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] a, b, d;
    logic       bin, bo, da, ra, ebo, saw_done;
    longint     ed;
    int         lat;
    op8(8'h00, 8'h01, 1'b0, d, bo, lat, da, ra);
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'b1; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus8.ready, bus8.busy, bus8.done, bus8.diff, bus8.bout} !== {3'b100, 8'h00, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_mid_async: rdy/busy/done=%b%b%b diff=%h bout=%b, want 100 00 0",
               bus8.ready, bus8.busy, bus8.done, bus8.diff, bus8.bout);
    end
    saw_done = 1'b0;
    repeat (2) begin tick(); if (bus8.done) saw_done = 1'b1; end
    rst_n = 1'b1;
    repeat (11) begin tick(); if (bus8.done) saw_done = 1'b1; end
    n_checks++;
    if (saw_done) begin
      n_errors++;
      $display("FAIL reset_mid_no_done: done=1 seen after reset, want 0");
    end
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    op8(a, b, bin, d, bo, lat, da, ra);
    model(8, longint'(a), longint'(b), longint'(bin), ed, ebo);
    n_checks++;
    if (d !== ed[7:0] || bo !== ebo || lat != 8) begin
      n_errors++;
      $display("FAIL reset_mid_after: diff=%h bout=%b lat=%0d, want %h %b 8",
               d, bo, lat, ed[7:0], ebo);
    end
  endtask

  task automatic test_width1();
    logic   a, b, bin, d, bo, ebo;
    logic [2:0] v;
    longint ed;
    int     lat;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a = v[2]; b = v[1]; bin = v[0];
      op1(a, b, bin, d, bo, lat);
      model(1, longint'(a), longint'(b), longint'(bin), ed, ebo);
      n_checks++;
      if (d !== ed[0] || bo !== ebo || lat != 1) begin
        n_errors++;
        $display("FAIL width1[%b%b%b]: diff=%b bout=%b lat=%0d, want %b %b 1",
                 a, b, bin, d, bo, lat, ed[0], ebo);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
